// File: rtl/cbd_stream_sampler.sv
// -----------------------------------------------------------------------------
// cbd_stream_sampler
//   Centered binomial distribution sampler. It turns a stream of PRF bytes into
//   NCOEFF noise coefficients, each of the form
//   popcount(ETA bits) - popcount(next ETA bits).
//   One start produces exactly one polynomial: 64*ETA bytes in, NCOEFF
//   coefficients out.
//
// Parameters
//   ETA     noise parameter, 2 or 3 (any other value fails elaboration)
//   NCOEFF  coefficients per polynomial (default 256)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        begin one polynomial (honoured only in IDLE)
//   in_byte      PRF byte, qualified by in_valid / in_ready
//   in_valid     in_byte is valid
//   in_ready     sampler accepts in_byte this cycle
//   coeff        coefficient: 4-bit signed, or 12-bit mod 3329 with
//                CBD_MODQ_EN defined
//   coeff_idx    index of coeff within the polynomial
//   coeff_valid  coeff / coeff_idx valid
//   coeff_ready  downstream accepts coeff
//   busy         high while a polynomial is in progress
//   done         one-cycle pulse after the last coefficient handshake
//
// Build option
//   CBD_MODQ_EN  when defined, emit coefficients reduced mod q = 3329
// -----------------------------------------------------------------------------
module cbd_stream_sampler #(
    parameter int ETA    = 2,
    parameter int NCOEFF = 256,
`ifdef CBD_MODQ_EN
    localparam int CW    = 12
`else
    localparam int CW    = 4
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    in_byte,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [CW-1:0] coeff,
    output logic [7:0]    coeff_idx,
    output logic          coeff_valid,
    input  logic          coeff_ready,
    output logic          busy,
    output logic          done
);

    if (ETA != 2 && ETA != 3) begin : g_eta_check
        $error("cbd_stream_sampler: ETA must be 2 or 3");
    end

    localparam int unsigned ETA_U    = ETA;
    localparam logic [7:0]  NBYTES   = 8'(64 * ETA);
    localparam logic [4:0]  STEP     = 5'(2 * ETA);
    localparam logic [7:0]  LAST_IDX = 8'(NCOEFF - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state;
    logic [15:0]   bits;
    logic [4:0]    fill;
    logic [7:0]    bytes_taken;
    logic [8:0]    load_cnt;

    logic          take;
    logic          hs;
    logic          load;
    logic [15:0]   merged;
    logic [4:0]    mfill;
    logic [2:0]    pos_cnt;
    logic [2:0]    neg_cnt;
    logic [CW-1:0] coeff_next;

    assign in_ready = (state == S_RUN) && (bytes_taken < NBYTES) && (fill <= 5'd8);
    assign take     = in_valid && in_ready;
    assign hs       = coeff_valid && coeff_ready;

    // The incoming byte is merged ahead of the coefficient extraction so that a
    // byte completing 2*ETA bits can be sampled in the same cycle it arrives.
    // fill <= 8 whenever a byte is taken, so the merge never overflows 16 bits.
    always_comb begin
        merged = bits;
        mfill  = fill;
        if (take) begin
            merged = bits | (16'(in_byte) << fill);
            mfill  = fill + 5'd8;
        end

        pos_cnt = '0;
        neg_cnt = '0;
        for (int unsigned i = 0; i < ETA_U; i++) begin
            pos_cnt = pos_cnt + 3'(merged[i]);
            neg_cnt = neg_cnt + 3'(merged[ETA_U + i]);
        end

`ifdef CBD_MODQ_EN
        if (neg_cnt > pos_cnt)
            coeff_next = 12'd3329 - {9'd0, 3'(neg_cnt - pos_cnt)};
        else
            coeff_next = {9'd0, 3'(pos_cnt - neg_cnt)};
`else
        coeff_next = 4'({1'b0, pos_cnt}) - 4'({1'b0, neg_cnt});
`endif

        load = (state == S_RUN) && (mfill >= STEP) && (!coeff_valid || hs)
               && (load_cnt < 9'(NCOEFF));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            bits        <= '0;
            fill        <= '0;
            bytes_taken <= '0;
            load_cnt    <= '0;
            coeff       <= '0;
            coeff_idx   <= '0;
            coeff_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RUN;
                        busy        <= 1'b1;
                        bits        <= '0;
                        fill        <= '0;
                        bytes_taken <= '0;
                        load_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (take)
                        bytes_taken <= bytes_taken + 8'd1;
                    if (load) begin
                        bits        <= merged >> (2 * ETA);
                        fill        <= mfill - STEP;
                        coeff       <= coeff_next;
                        coeff_idx   <= load_cnt[7:0];
                        coeff_valid <= 1'b1;
                        load_cnt    <= load_cnt + 9'd1;
                    end else begin
                        bits <= merged;
                        fill <= mfill;
                        if (hs)
                            coeff_valid <= 1'b0;
                    end
                    if (hs && coeff_idx == LAST_IDX) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbd_stream_sampler.sv
module tb_cbd_stream_sampler;

`ifdef CBD_MODQ_EN
    localparam int CW = 12;
`else
    localparam int CW = 4;
`endif

    logic          clk = 1'b0;
    logic          reset, start, in_valid, coeff_ready;
    logic [7:0]    in_byte;

    logic          ir2, cv2, busy2, done2, ir3, cv3, busy3, done3;
    logic [CW-1:0] c2, c3;
    logic [7:0]    idx2, idx3;

    bit            sel3;
    logic          o_ir, o_cv, o_busy, o_done;
    logic [CW-1:0] o_coeff;
    logic [7:0]    o_idx;

    always #5 clk = ~clk;

    cbd_stream_sampler #(.ETA(2), .NCOEFF(256)) dut2 (
        .clk(clk), .reset(reset), .start(start), .in_byte(in_byte),
        .in_valid(in_valid), .in_ready(ir2), .coeff(c2), .coeff_idx(idx2),
        .coeff_valid(cv2), .coeff_ready(coeff_ready), .busy(busy2), .done(done2)
    );

    cbd_stream_sampler #(.ETA(3), .NCOEFF(256)) dut3 (
        .clk(clk), .reset(reset), .start(start), .in_byte(in_byte),
        .in_valid(in_valid), .in_ready(ir3), .coeff(c3), .coeff_idx(idx3),
        .coeff_valid(cv3), .coeff_ready(coeff_ready), .busy(busy3), .done(done3)
    );

    assign o_ir    = sel3 ? ir3   : ir2;
    assign o_cv    = sel3 ? cv3   : cv2;
    assign o_busy  = sel3 ? busy3 : busy2;
    assign o_done  = sel3 ? done3 : done2;
    assign o_coeff = sel3 ? c3    : c2;
    assign o_idx   = sel3 ? idx3  : idx2;

    int            n_checks = 0;
    int            n_errors = 0;

    logic [7:0]    stim [0:191];
    logic [CW-1:0] got_v [$];
    logic [7:0]    got_i [$];
    int            sent, done_cnt, run_cycles;
    bit            ready_late, stall_ok, saw_low, busy_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: coefficient i uses stream bits [2*eta*i, 2*eta*i+2*eta),
    // stream bit k being bit k%8 of byte k/8.
    function automatic int bit_at(input int k);
        return int'((stim[k / 8] >> (k % 8)) & 8'd1);
    endfunction

    function automatic int golden(input int eta, input int i);
        int a = 0;
        int b = 0;
        for (int j = 0; j < eta; j++) begin
            a += bit_at(2 * eta * i + j);
            b += bit_at(2 * eta * i + eta + j);
        end
        return a - b;
    endfunction

    function automatic logic [CW-1:0] enc(input int v);
`ifdef CBD_MODQ_EN
        return (v < 0) ? CW'(3329 + v) : CW'(v);
`else
        return CW'(v);
`endif
    endfunction

    task automatic fill_stim(input int mode);
        for (int i = 0; i < 192; i++)
            stim[i] = (mode == 0) ? 8'h00 : 8'($urandom);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; coeff_ready = 1'b1;
        @(negedge clk);
        #1;
        check({tag, ".in_ready"},    32'(o_ir),    32'd0);
        check({tag, ".coeff_valid"}, 32'(o_cv),    32'd0);
        check({tag, ".coeff"},       32'(o_coeff), 32'd0);
        check({tag, ".coeff_idx"},   32'(o_idx),   32'd0);
        check({tag, ".busy"},        32'(o_busy),  32'd0);
        check({tag, ".done"},        32'(o_done),  32'd0);
        reset = 1'b0;
    endtask

    task automatic run_poly(input int stall_at, input int abort_at, input int start_at,
                            input bit rand_valid);
        int            nb;
        int            stall_left;
        bit            stall_done;
        bit            held;
        logic [CW-1:0] hc;
        logic [7:0]    hi;
        nb = sel3 ? 192 : 128;
        stall_left = 0; stall_done = 0; held = 0; hc = '0; hi = '0;
        got_v.delete(); got_i.delete();
        sent = 0; done_cnt = 0; run_cycles = 0;
        ready_late = 0; stall_ok = 1; saw_low = 0; busy_seen = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start    = (cyc == 0) || (cyc == start_at);
            in_valid = (sent < nb) && (!rand_valid || $urandom_range(0, 2) != 0);
            in_byte  = (sent < nb) ? stim[sent] : 8'hA5;
            if (stall_at >= 0 && !stall_done && got_v.size() == stall_at) begin
                stall_left = 10; stall_done = 1; held = 0;
            end
            coeff_ready = (stall_left == 0);
            #1;
            run_cycles = cyc;
            if (cyc == 2) busy_seen = o_busy;
            if (stall_left > 0) begin
                if (!o_ir) saw_low = 1;
                if (held && (o_cv !== 1'b1 || o_coeff !== hc || o_idx !== hi)) stall_ok = 0;
                if (!held && o_cv) begin held = 1; hc = o_coeff; hi = o_idx; end
                stall_left--;
            end
            if (sent == nb && o_ir !== 1'b0) ready_late = 1;
            if (in_valid && o_ir) sent++;
            if (o_cv && coeff_ready) begin
                got_v.push_back(o_coeff);
                got_i.push_back(o_idx);
            end
            if (o_done) begin done_cnt++; break; end
            if (abort_at >= 0 && got_v.size() == abort_at) break;
        end
        start = 1'b0; in_valid = 1'b0; coeff_ready = 1'b1;
    endtask

    task automatic check_poly(input string tag);
        int nb;
        int eta;
        int bad;
        int first;
        nb = sel3 ? 192 : 128;
        eta = sel3 ? 3 : 2;
        bad = 0;
        first = -1;
        for (int i = 0; i < got_v.size(); i++) begin
            if (got_i[i] !== 8'(i) || got_v[i] !== enc(golden(eta, i))) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        check({tag, ".count"},       32'(got_v.size()), 32'd256);
        check({tag, ".bad_values"},  32'(bad),          32'd0);
        check({tag, ".done_cnt"},    32'(done_cnt),     32'd1);
        check({tag, ".bytes"},       32'(sent),         32'(nb));
        check({tag, ".ready_late"},  32'(ready_late),   32'd0);
        check({tag, ".busy_in_run"}, 32'(busy_seen),    32'd1);
        if (first >= 0) $display("%s first bad index %0d", tag, first);
        @(negedge clk);
        #1;
        check({tag, ".done_after"},  32'(o_done), 32'd0);
        check({tag, ".busy_after"},  32'(o_busy), 32'd0);
        check({tag, ".ready_after"}, 32'(o_ir),   32'd0);
    endtask

    initial begin
        sel3 = 0;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; coeff_ready = 1'b1;
        apply_reset("por");

        // ETA=2 directed bytes
        fill_stim(0); stim[0] = 8'h03;
        run_poly(-1, -1, -1, 0);
        check("e2_03.idx0", 32'(got_v[0]), 32'(enc(2)));
        check("e2_03.idx1", 32'(got_v[1]), 32'(enc(0)));
        check_poly("e2_03");

        fill_stim(0); stim[0] = 8'hC0;
        run_poly(-1, -1, -1, 0);
        check("e2_c0.idx0", 32'(got_v[0]), 32'(enc(0)));
`ifdef CBD_MODQ_EN
        check("e2_c0.idx1", 32'(got_v[1]), 32'd3327);
`else
        check("e2_c0.idx1", 32'(got_v[1]), 32'b1110);
`endif
        check_poly("e2_c0");

        // random polynomial, nothing stalled: one coefficient per cycle
        fill_stim(1);
        run_poly(-1, -1, -1, 0);
        check_poly("e2_rand");
        check("e2_rand.cycles_le_260", 32'(run_cycles <= 260), 32'd1);

        // downstream stall of 10 cycles mid-stream
        fill_stim(1);
        run_poly(40, -1, -1, 0);
        check_poly("e2_stall");
        check("e2_stall.stable",    32'(stall_ok), 32'd1);
        check("e2_stall.ready_low", 32'(saw_low),  32'd1);

        // start pulsed during RUN with a bursty source
        fill_stim(1);
        run_poly(-1, -1, 60, 1);
        check_poly("e2_start_mid");

        // reset after 100 coefficient handshakes, then a full polynomial
        fill_stim(1);
        run_poly(-1, 100, -1, 0);
        check("mid.handshakes", 32'(got_v.size()), 32'd100);
        check("mid.busy",       32'(o_busy),       32'd1);
        apply_reset("mid_reset");
        fill_stim(1);
        run_poly(-1, -1, -1, 0);
        check_poly("e2_after_reset");

        // ETA=3 instance
        sel3 = 1;
        apply_reset("e3_reset");
        fill_stim(0); stim[0] = 8'h07;
        run_poly(-1, -1, -1, 0);
        check("e3_07.idx0", 32'(got_v[0]), 32'(enc(3)));
        check("e3_07.idx1", 32'(got_v[1]), 32'(enc(0)));
        check("e3_07.idx2", 32'(got_v[2]), 32'(enc(0)));
        check("e3_07.idx3", 32'(got_v[3]), 32'(enc(0)));
        check_poly("e3_07");

        fill_stim(0); stim[0] = 8'h38;
        run_poly(-1, -1, -1, 0);
        check("e3_38.idx0", 32'(got_v[0]), 32'(enc(-3)));
        check("e3_38.idx1", 32'(got_v[1]), 32'(enc(0)));
        check("e3_38.idx2", 32'(got_v[2]), 32'(enc(0)));
        check("e3_38.idx3", 32'(got_v[3]), 32'(enc(0)));
        check_poly("e3_38");

        fill_stim(1);
        run_poly(20, -1, -1, 1);
        check_poly("e3_rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cbd_stream_sampler.md
CBD_STREAM_SAMPLER -- requirements
Module: cbd_stream_sampler

Interface
REQ-001 SHALL have parameter ETA, default 2, noise parameter; legal values 2 or 3, any other value a elaboration error.
REQ-002 SHALL have parameter NCOEFF, default 256, coefficients per polynomial.
REQ-003 SHALL have port clk, input, 1 bit, single clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit, begin one polynomial; honoured only in IDLE.
REQ-006 SHALL have port in_byte, input, 8 bits, PRF output byte.
REQ-007 SHALL have port in_valid, input, 1 bit, in_byte valid.
REQ-008 SHALL have port in_ready, output, 1 bit, sampler accepts in_byte.
REQ-009 SHALL have port coeff, output, CW bits: CW=4, signed two's complement, without CBD_MODQ_EN; CW=12, unsigned, with it.
REQ-010 SHALL have port coeff_idx, output, 8 bits, index 0..NCOEFF-1 of coeff.
REQ-011 SHALL have port coeff_valid, output, 1 bit, coeff/coeff_idx valid.
REQ-012 SHALL have port coeff_ready, input, 1 bit, downstream accepts coeff.
REQ-013 SHALL have port busy, output, 1 bit, high in RUN.
REQ-014 SHALL have port done, output, 1 bit, one-cycle pulse after last coefficient handshake.

Function
REQ-015 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE on handshake of coefficient NCOEFF-1; DONE -> IDLE unconditionally next cycle.
REQ-016 SHALL clear byte counter, coefficient counter and bit buffer on IDLE -> RUN.
REQ-017 SHALL hold a 16-bit bit buffer with 5-bit fill count; accepted bytes append above current fill, bits consumed LSB-first.
REQ-018 SHALL drive in_ready = RUN and bytes_taken < 64*ETA and fill <= 8; byte transfer occurs when in_valid and in_ready are both high.
REQ-019 SHALL compute each coefficient from the lowest 2*ETA buffer bits: a = popcount(bits[ETA-1:0]), b = popcount(bits[2*ETA-1:ETA]), value = a - b, range -ETA..ETA.
REQ-020 SHALL load the output register when fill >= 2*ETA and either coeff_valid is low or the current coeff is handshaken that cycle, shifting buffer by 2*ETA.
REQ-021 SHALL present coeff_valid in the cycle after the byte handshake that completes 2*ETA bits, giving one-cycle latency.
REQ-022 SHALL hold coeff, coeff_idx and coeff_valid stable while coeff_valid is high and coeff_ready is low.
REQ-023 SHALL sustain one coefficient per cycle when input and output are never stalled.
REQ-024 SHALL consume exactly 64*ETA bytes and emit exactly NCOEFF coefficients per start; in_ready stays low after the last byte until the next start.
REQ-025 SHALL ignore start while busy or in DONE.
REQ-026 SHALL handle a simultaneous byte append and coefficient shift in one cycle; fill updates by +8-2*ETA.

Reset
REQ-027 SHALL on reset, including mid-operation, go to IDLE next edge with in_ready=0, coeff_valid=0, coeff=0, coeff_idx=0, busy=0, done=0, fill=0 and counters=0; partial polynomial discarded.

Configuration
REQ-028 SHALL provide macro CBD_MODQ_EN: when defined, coeff is 12-bit value mod 3329; negatives map to 3329+value, e.g. -1 -> 3328.
REQ-029 SHALL, without CBD_MODQ_EN, output coeff as 4-bit signed two's complement of value with no modular reduction logic.

Verification
REQ-030 SHALL cover: ETA=2, byte 0x03 -> coeff idx0=+2, idx1=0; byte 0xC0 -> idx0=0, idx1=-2 (4'b1110), or 3327 with CBD_MODQ_EN.
REQ-031 SHALL cover: ETA=3, bytes 0x07,0x00,0x00 -> coeffs +3,0,0,0; bytes 0x38,0x00,0x00 -> -3,0,0,0.
REQ-032 SHALL cover: ETA=2, 128 random bytes, coeff_ready always high -> 256 coeffs idx 0..255 matching golden CBD model, done pulses once, in_ready low after 128th byte.
REQ-033 SHALL cover: coeff_ready held low 10 cycles mid-stream -> coeff stable, in_ready falls once fill > 8, no byte or coeff lost.
REQ-034 SHALL cover: reset asserted after 100 coeff handshakes -> next cycle all outputs 0, new start yields full 256-coefficient polynomial from idx 0.
REQ-035 SHALL cover: start pulsed during RUN -> ignored, coefficient stream and counts unchanged.
